// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot sequencing and fetch/load arbitration for the single-ported instruction memory
module imem_arbiter #(
    parameter int MEM_WORDS = 65536,
    parameter int ADDR_W    = 16,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [31:0]       fetchAddr,
    output logic              fetchGrant,
    output logic              fetchValid,
    output logic [31:0]       fetchData,
    output logic              fetchErr,
    input  logic              loadReq,
    input  logic [31:0]       loadAddr,
    input  logic [31:0]       loadData,
    output logic              loadGrant,
    output logic              loadErr,
    input  logic              loadDone,
    output logic              bootDone,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memEn,
    output logic              memWe,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t     state, stateNext;
    logic [3:0] waitCnt;
    logic       rdPending;
    logic       fetchOk, loadOk, fetchBad, loadBad;

    function automatic logic isBad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
    endfunction

    assign fetchBad = isBad(fetchAddr);
    assign loadBad  = isBad(loadAddr);
    assign fetchOk  = fetchReq && !fetchBad;
    assign loadOk   = loadReq && !loadBad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == BOOT && loadDone) begin
            stateNext = RUN;
        end
    end

    // Fetch has priority in RUN unless the loader has already lost MAX_WAIT times in a row.
    always_comb begin
        fetchGrant = 1'b0;
        loadGrant  = 1'b0;
        bootDone   = 1'b0;
        case (state)
            BOOT: begin
                loadGrant = loadOk;
            end
            RUN: begin
                bootDone = 1'b1;
                if (loadOk && (!fetchOk || waitCnt == 4'(MAX_WAIT))) begin
                    loadGrant = 1'b1;
                end else begin
                    fetchGrant = fetchOk;
                end
            end
            default: begin
                fetchGrant = 1'b0;
            end
        endcase
    end

    always_comb begin
        memEn    = fetchGrant || loadGrant;
        memWe    = loadGrant;
        memAddr  = '0;
        memWData = '0;
        if (loadGrant) begin
            memAddr  = loadAddr[ADDR_W+1:2];
            memWData = loadData;
        end else if (fetchGrant) begin
            memAddr  = fetchAddr[ADDR_W+1:2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt   <= '0;
            rdPending <= 1'b0;
            fetchErr  <= 1'b0;
            loadErr   <= 1'b0;
        end else begin
            rdPending <= fetchGrant;
            fetchErr  <= (state == RUN) && fetchReq && fetchBad;
            loadErr   <= loadReq && loadBad;
            if (loadGrant) begin
                waitCnt <= '0;
            end else if (state == RUN && loadOk) begin
                waitCnt <= waitCnt + 4'd1;
            end
        end
    end

    assign fetchValid = rdPending;
    assign fetchData  = rdPending ? memRData : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter against a cycle-level reference model
module tb_imem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetchReq = 1'b0;
    logic [31:0] fetchAddr = '0;
    logic        fetchGrant, fetchValid, fetchErr;
    logic [31:0] fetchData;
    logic        loadReq = 1'b0;
    logic [31:0] loadAddr = '0;
    logic [31:0] loadData = '0;
    logic        loadGrant, loadErr;
    logic        loadDone = 1'b0;
    logic        bootDone;
    logic [15:0] memAddr;
    logic        memEn, memWe;
    logic [31:0] memWData;
    logic [31:0] memRData = '0;

    int nChecks = 0;
    int nFails  = 0;

    imem_arbiter #(.MEM_WORDS(65536), .ADDR_W(16), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
        .fetchValid(fetchValid), .fetchData(fetchData), .fetchErr(fetchErr),
        .loadReq(loadReq), .loadAddr(loadAddr), .loadData(loadData),
        .loadGrant(loadGrant), .loadErr(loadErr), .loadDone(loadDone),
        .bootDone(bootDone), .memAddr(memAddr), .memEn(memEn), .memWe(memWe),
        .memWData(memWData), .memRData(memRData)
    );

    always #5 clk = ~clk;

    // Single-ported synchronous memory the arbiter drives.
    bit [31:0] envMem [65536];
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) envMem[memAddr] <= memWData;
            else       memRData <= envMem[memAddr];
        end
    end

    // Reference model state.
    bit [31:0]   refMem [65536];
    bit          mBoot;
    int          mLoss;
    bit          expFG, expLG, expFV, expFE, expLE;
    logic [31:0] expFD;

    function automatic bit bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 65536);
    endfunction

    task automatic resetModel();
        mBoot = 1; mLoss = 0;
        expFG = 0; expLG = 0; expFV = 0; expFE = 0; expLE = 0; expFD = 0;
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit lr,
                         input logic [31:0] la, input logic [31:0] ld, input bit dn);
        bit fg, lg;
        fetchReq = fr; fetchAddr = fa; loadReq = lr; loadAddr = la; loadData = ld; loadDone = dn;
        fg = fr && !bad(fa);
        lg = lr && !bad(la);
        if (mBoot) begin
            expFG = 0;
            expLG = lg;
        end else begin
            expLG = lg && (!fg || mLoss == MAXW);
            expFG = fg && !expLG;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        expFV = expFG;
        expFD = expFG ? refMem[fetchAddr / 4] : 32'd0;
        if (expLG) refMem[loadAddr / 4] = loadData;
        expFE = !mBoot && fetchReq && bad(fetchAddr);
        expLE = loadReq && bad(loadAddr);
        if (!mBoot) begin
            if (expLG) mLoss = 0;
            else if (loadReq && !bad(loadAddr)) mLoss++;
        end
        if (mBoot && loadDone) mBoot = 0;
        #1;
    endtask

    task automatic doReset();
        reset = 1;
        fetchReq = 0; fetchAddr = 0; loadReq = 0; loadAddr = 0; loadData = 0; loadDone = 0;
        resetModel();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (bootDone !== 1'b0) begin nFails++; $display("FAIL reset_bootDone got %0b want 0", bootDone); end
        nChecks++;
        if ({fetchValid, fetchErr, loadErr} !== 3'b000) begin
            nFails++; $display("FAIL reset_flags got %b want 000", {fetchValid, fetchErr, loadErr});
        end
        nChecks++;
        if ({memEn, memWe, memAddr, memWData} !== 50'd0) begin
            nFails++; $display("FAIL reset_idle_mem got en=%0b we=%0b a=%h d=%h want all 0", memEn, memWe, memAddr, memWData);
        end
    endtask

    task automatic test_fetch_in_boot();
        drive(1, 32'h0, 0, 0, 0, 0);
        nChecks++;
        if (fetchGrant !== 1'b0 || memEn !== 1'b0) begin
            nFails++; $display("FAIL boot_fetch_grant got g=%0b en=%0b want 0 0", fetchGrant, memEn);
        end
        tick();
        nChecks++;
        if (fetchValid !== 1'b0 || fetchErr !== 1'b0) begin
            nFails++; $display("FAIL boot_fetch_resp got v=%0b e=%0b want 0 0", fetchValid, fetchErr);
        end
    endtask

    task automatic test_boot_load();
        logic [31:0] words [3];
        words[0] = 32'h20080005; words[1] = 32'h20090003; words[2] = 32'h01095020;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'(i * 4), words[i], i == 2);
            nChecks++;
            if (loadGrant !== 1'b1 || memEn !== 1'b1 || memWe !== 1'b1) begin
                nFails++; $display("FAIL boot_load_grant[%0d] got g=%0b en=%0b we=%0b want 1 1 1", i, loadGrant, memEn, memWe);
            end
            nChecks++;
            if (memAddr !== 16'(i) || memWData !== words[i]) begin
                nFails++; $display("FAIL boot_load_bus[%0d] got a=%h d=%h want %h %h", i, memAddr, memWData, 16'(i), words[i]);
            end
            nChecks++;
            if (bootDone !== 1'b0) begin nFails++; $display("FAIL boot_early_done[%0d] got 1 want 0", i); end
            tick();
        end
        nChecks++;
        if (bootDone !== 1'b1) begin nFails++; $display("FAIL boot_done got %0b want 1", bootDone); end
        drive(1, 32'h4, 0, 0, 0, 0);
        nChecks++;
        if (fetchGrant !== 1'b1 || memAddr !== 16'd1 || memWe !== 1'b0) begin
            nFails++; $display("FAIL first_fetch_grant got g=%0b a=%h we=%0b want 1 0001 0", fetchGrant, memAddr, memWe);
        end
        tick();
        nChecks++;
        if (fetchValid !== 1'b1 || fetchData !== 32'h20090003) begin
            nFails++; $display("FAIL first_fetch_data got v=%0b d=%h want 1 20090003", fetchValid, fetchData);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        nChecks++;
        if (fetchValid !== 1'b0 || fetchData !== 32'd0) begin
            nFails++; $display("FAIL fetch_valid_drop got v=%0b d=%h want 0 0", fetchValid, fetchData);
        end
    endtask

    task automatic test_bad_addr();
        drive(1, 32'h6, 0, 0, 0, 0);
        nChecks++;
        if (fetchGrant !== 1'b0 || memEn !== 1'b0) begin
            nFails++; $display("FAIL bad_fetch_grant got g=%0b en=%0b want 0 0", fetchGrant, memEn);
        end
        tick();
        nChecks++;
        if (fetchErr !== 1'b1 || fetchValid !== 1'b0) begin
            nFails++; $display("FAIL bad_fetch_err got e=%0b v=%0b want 1 0", fetchErr, fetchValid);
        end
        drive(0, 0, 1, 32'h40000, 32'hDEADBEEF, 0);
        nChecks++;
        if (loadGrant !== 1'b0 || memEn !== 1'b0) begin
            nFails++; $display("FAIL bad_load_grant got g=%0b en=%0b want 0 0", loadGrant, memEn);
        end
        tick();
        nChecks++;
        if (loadErr !== 1'b1 || fetchErr !== 1'b0) begin
            nFails++; $display("FAIL bad_load_err got le=%0b fe=%0b want 1 0", loadErr, fetchErr);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        nChecks++;
        if (loadErr !== 1'b0) begin nFails++; $display("FAIL bad_load_pulse got %0b want 0", loadErr); end
    endtask

    task automatic test_contention();
        bit wantLoad;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'((i % 3) * 4), 1, 32'h40, 32'hCAFEF00D, 0);
            wantLoad = (i == MAXW);
            nChecks++;
            if (loadGrant !== wantLoad || fetchGrant !== !wantLoad) begin
                nFails++; $display("FAIL contention[%0d] got fg=%0b lg=%0b want %0b %0b", i, fetchGrant, loadGrant, !wantLoad, wantLoad);
            end
            tick();
            nChecks++;
            if (fetchValid !== expFV || fetchData !== expFD) begin
                nFails++; $display("FAIL contention_rd[%0d] got v=%0b d=%h want %0b %h", i, fetchValid, fetchData, expFV, expFD);
            end
            if (wantLoad) begin
                loadReq = 0;
            end
        end
        drive(1, 32'h40, 0, 0, 0, 0);
        tick();
        nChecks++;
        if (fetchValid !== 1'b1 || fetchData !== 32'hCAFEF00D) begin
            nFails++; $display("FAIL contention_readback got v=%0b d=%h want 1 cafef00d", fetchValid, fetchData);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] words [3];
        words[0] = 32'h20080005; words[1] = 32'h20090003; words[2] = 32'h01095020;
        drive(1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) drive(1, 32'((i + 1) * 4), 0, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0);
            nChecks++;
            if (fetchValid !== 1'b1 || fetchData !== words[i]) begin
                nFails++; $display("FAIL stream[%0d] got v=%0b d=%h want 1 %h", i, fetchValid, fetchData, words[i]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        bit          lPend = 0;
        logic [31:0] la = 0, ld = 0, fa;
        bit          fr;
        logic [15:0] wantAddr;
        for (int c = 0; c < 400; c++) begin
            if (!lPend) begin
                lPend = ($urandom % 3) == 0;
                la = (($urandom % 10) == 0) ? 32'h40000 + 32'($urandom_range(0, 3) * 4)
                                            : 32'($urandom_range(0, 15) * 4);
                ld = $urandom;
            end
            fr = ($urandom % 4) != 0;
            fa = 32'($urandom_range(0, 15) * 4) + ((($urandom % 8) == 0) ? 32'd2 : 32'd0);
            drive(fr, fa, lPend, la, ld, 0);
            wantAddr = expLG ? la[17:2] : (expFG ? fa[17:2] : 16'd0);
            nChecks++;
            if (fetchGrant !== expFG || loadGrant !== expLG) begin
                nFails++; $display("FAIL rand_grant[%0d] got fg=%0b lg=%0b want %0b %0b", c, fetchGrant, loadGrant, expFG, expLG);
            end
            nChecks++;
            if (memEn !== (expFG || expLG) || memWe !== expLG || memAddr !== wantAddr) begin
                nFails++; $display("FAIL rand_bus[%0d] got en=%0b we=%0b a=%h want %0b %0b %h", c, memEn, memWe, memAddr, expFG || expLG, expLG, wantAddr);
            end
            if (expLG || bad(la)) lPend = 0;
            tick();
            nChecks++;
            if (fetchValid !== expFV || fetchData !== expFD) begin
                nFails++; $display("FAIL rand_read[%0d] got v=%0b d=%h want %0b %h", c, fetchValid, fetchData, expFV, expFD);
            end
            nChecks++;
            if (fetchErr !== expFE || loadErr !== expLE) begin
                nFails++; $display("FAIL rand_err[%0d] got fe=%0b le=%0b want %0b %0b", c, fetchErr, loadErr, expFE, expLE);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 32'h4, 0, 0, 0, 0);
        nChecks++;
        if (fetchGrant !== 1'b1) begin nFails++; $display("FAIL midrd_grant got %0b want 1", fetchGrant); end
        tick();
        #1;
        reset = 1;
        fetchReq = 0;
        resetModel();
        #1;
        nChecks++;
        if (fetchValid !== 1'b0 || fetchData !== 32'd0 || bootDone !== 1'b0) begin
            nFails++; $display("FAIL midrd_async got v=%0b d=%h bd=%0b want 0 0 0", fetchValid, fetchData, bootDone);
        end
        @(posedge clk);
        #1;
        reset = 0;
        nChecks++;
        if (fetchValid !== 1'b0 || bootDone !== 1'b0) begin
            nFails++; $display("FAIL midrd_after got v=%0b bd=%0b want 0 0", fetchValid, bootDone);
        end
        drive(1, 32'h0, 0, 0, 0, 0);
        nChecks++;
        if (fetchGrant !== 1'b0) begin nFails++; $display("FAIL midrd_boot_grant got %0b want 0", fetchGrant); end
        tick();
        nChecks++;
        if (fetchValid !== 1'b0 || fetchErr !== 1'b0) begin
            nFails++; $display("FAIL midrd_boot_resp got v=%0b e=%0b want 0 0", fetchValid, fetchErr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_in_boot();
        test_boot_load();
        test_bad_addr();
        test_contention();
        test_streaming();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
